// File: rtl/tf_table_loader.sv
// Run-time loadable twiddle-factor table: a valid/ready stream fills the RAM, then an FFT
// stage reads it sequentially with wraparound and one cycle of latency.
module tf_table_loader #(
    parameter int unsigned float_len   = 32,
    parameter int unsigned tf_num      = 4,
    parameter int unsigned tf_addr_len = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [2*float_len-1:0]   wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    output logic                     wr_drop,
    output logic                     load_done,
    output logic                     table_ready,
    input  logic                     rd_en,
    output logic [2*float_len-1:0]   rd_data,
    output logic                     rd_data_valid
);

    localparam logic [tf_addr_len-1:0] LastAddr = tf_addr_len'(tf_num - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StReady
    } state_e;

    state_e                   state;
    logic [tf_addr_len-1:0]   waddr;
    logic [tf_addr_len-1:0]   raddr;
    logic [2*float_len-1:0]   mem [tf_num];

    logic wr_fire;
    logic rd_fire;

    // A beat coincident with load_start belongs to neither the old nor the new load.
    assign wr_ready = (state == StLoad) && !load_start;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_en && (state == StReady);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            waddr         <= '0;
            raddr         <= '0;
            wr_drop       <= 1'b0;
            load_done     <= 1'b0;
            table_ready   <= 1'b0;
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
        end else begin
            load_done     <= 1'b0;
            rd_data_valid <= rd_fire;

            if (rd_fire) begin
                rd_data <= mem[raddr];
                raddr   <= raddr + 1'b1;
            end

            if (load_start) begin
                state       <= StLoad;
                waddr       <= '0;
                raddr       <= '0;
                table_ready <= 1'b0;
                wr_drop     <= 1'b0;
            end else if (wr_fire) begin
                waddr <= waddr + 1'b1;
                if (waddr == LastAddr) begin
                    state       <= StReady;
                    load_done   <= 1'b1;
                    table_ready <= 1'b1;
                end
            end

            // Placed after the restart clear so a dropped beat on the restart cycle still flags.
            if (wr_valid && !wr_ready) begin
                wr_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tf_table_loader.sv
// Directed bench for tf_table_loader: load, wrapping reads, drops, abort, reload and reset.
module tb_tf_table_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [63:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_drop;
    logic        load_done;
    logic        table_ready;
    logic        rd_en;
    logic [63:0] rd_data;
    logic        rd_data_valid;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] tbl [4];
    logic [63:0] alt [4];

    tf_table_loader #(
        .float_len   (32),
        .tf_num      (4),
        .tf_addr_len (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_start    (load_start),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_drop       (wr_drop),
        .load_done     (load_done),
        .table_ready   (table_ready),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge so registered outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
        check({tag, "_wr_drop"}, 64'(wr_drop), 64'd0);
        check({tag, "_load_done"}, 64'(load_done), 64'd0);
        check({tag, "_table_ready"}, 64'(table_ready), 64'd0);
        check({tag, "_rd_data"}, rd_data, 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_data_valid), 64'd0);
    endtask

    task automatic pulse_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        tbl[0] = 64'h3F800000_00000000;
        tbl[1] = 64'h3F3504F3_BF3504F3;
        tbl[2] = 64'h00000000_BF800000;
        tbl[3] = 64'hBF3504F3_BF3504F3;
        alt[0] = 64'h11111111_AAAAAAAA;
        alt[1] = 64'h22222222_BBBBBBBB;
        alt[2] = 64'h33333333_CCCCCCCC;
        alt[3] = 64'h44444444_DDDDDDDD;

        rst = 1'b1;
        load_start = 1'b0;
        wr_data = '0;
        wr_valid = 1'b0;
        rd_en = 1'b0;
        #3;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reads before any load are refused.
        rd_en = 1'b1;
        tick();
        check("preload_rd_valid", 64'(rd_data_valid), 64'd0);
        check("preload_rd_data", rd_data, 64'd0);
        tick();
        check("preload_rd_valid2", 64'(rd_data_valid), 64'd0);
        rd_en = 1'b0;

        // A beat in IDLE is dropped and flagged.
        wr_data = 64'hDEADBEEF_DEADBEEF;
        wr_valid = 1'b1;
        check("idle_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        wr_valid = 1'b0;
        check("idle_wr_drop", 64'(wr_drop), 64'd1);

        // Full load; load_start clears the drop flag.
        pulse_load();
        check("load_drop_cleared", 64'(wr_drop), 64'd0);
        check("load_table_ready0", 64'(table_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            wr_data = tbl[i];
            wr_valid = 1'b1;
            #1;
            check($sformatf("load_wr_ready%0d", i), 64'(wr_ready), 64'd1);
            check($sformatf("load_done_early%0d", i), 64'(load_done), 64'd0);
            tick();
        end
        wr_valid = 1'b0;
        check("load_done_pulse", 64'(load_done), 64'd1);
        check("load_table_ready", 64'(table_ready), 64'd1);
        check("load_wr_ready_after", 64'(wr_ready), 64'd0);
        tick();
        check("load_done_once", 64'(load_done), 64'd0);
        check("load_table_ready_hold", 64'(table_ready), 64'd1);

        // Six sequential reads wrap from entry 3 back to 0; the first proves raddr held at 0.
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rd_valid%0d", i), 64'(rd_data_valid), 64'd1);
            check($sformatf("rd_data%0d", i), rd_data, tbl[i % 4]);
        end
        rd_en = 1'b0;
        tick();
        check("rd_valid_off", 64'(rd_data_valid), 64'd0);
        check("rd_data_hold", rd_data, tbl[1]);

        // A beat in READY is dropped; table is unchanged; raddr continues from 2.
        wr_data = 64'hDEADBEEF_DEADBEEF;
        wr_valid = 1'b1;
        check("ready_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        wr_valid = 1'b0;
        check("ready_wr_drop", 64'(wr_drop), 64'd1);
        tick();
        check("ready_wr_drop_sticky", 64'(wr_drop), 64'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sweep_data%0d", i), rd_data, tbl[(i + 2) % 4]);
        end

        // Reload while reading: the coincident read is served, the next is refused.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("reload_rd_valid", 64'(rd_data_valid), 64'd1);
        check("reload_rd_data", rd_data, tbl[2]);
        check("reload_table_ready", 64'(table_ready), 64'd0);
        tick();
        check("reload_rd_refused", 64'(rd_data_valid), 64'd0);
        rd_en = 1'b0;

        // Two partial beats, then abort with a coincident beat, then a full new table.
        for (int i = 0; i < 2; i++) begin
            wr_data = 64'hDEADBEEF_DEADBEEF;
            wr_valid = 1'b1;
            tick();
        end
        load_start = 1'b1;
        wr_data = 64'hCAFEF00D_CAFEF00D;
        wr_valid = 1'b1;
        #1;
        check("abort_wr_ready", 64'(wr_ready), 64'd0);
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_data = alt[i];
            wr_valid = 1'b1;
            #1;
            check($sformatf("abort_wr_ready%0d", i), 64'(wr_ready), 64'd1);
            tick();
            if (i < 3) begin
                check($sformatf("abort_done_early%0d", i), 64'(load_done), 64'd0);
            end
        end
        wr_valid = 1'b0;
        check("abort_load_done", 64'(load_done), 64'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_rd_valid%0d", i), 64'(rd_data_valid), 64'd1);
            check($sformatf("abort_rd_data%0d", i), rd_data, alt[i]);
        end
        rd_en = 1'b0;
        tick();

        // Asynchronous reset while two entries into a load.
        pulse_load();
        for (int i = 0; i < 2; i++) begin
            wr_data = tbl[i];
            wr_valid = 1'b1;
            tick();
        end
        wr_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        #1;
        rst = 1'b0;
        rd_en = 1'b1;
        tick();
        check("postrst_rd_valid", 64'(rd_data_valid), 64'd0);
        check("postrst_rd_data", rd_data, 64'd0);
        tick();
        check("postrst_rd_valid2", 64'(rd_data_valid), 64'd0);
        check("postrst_table_ready", 64'(table_ready), 64'd0);
        rd_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tf_table_loader.md
Name: tf_table_loader

Overview:
- Writer and reader for a run-time-loadable twiddle-factor table, as an alternative to a fixed ROM.
- Accepts a stream of complex twiddle factors (re/im single-precision floats, packed) over a valid/ready handshake and writes them into an internal RAM.
- Once loaded, serves sequential wrapping reads to an FFT stage, with output valid one cycle after the read enable.
- Sits between the host/config path and a radix stage's butterfly.

Parameters:
- float_len, 32, bit width of one float; a word is 2*float_len bits, {re[63:32], im[31:0]} at default.
- tf_num, 4, number of twiddle factors in the table; must be a power of 2, at least 2.
- tf_addr_len, 2, log2(tf_num).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- load_start  in  1  one-cycle pulse that starts a new table load.
- wr_data  in  2*float_len  twiddle word being written.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  loader accepts wr_data this cycle.
- wr_drop  out  1  sticky flag: a wr_valid beat arrived while not loading.
- load_done  out  1  one-cycle pulse when the last entry is written.
- table_ready  out  1  table is fully loaded and readable.
- rd_en  in  1  read request from the consuming stage.
- rd_data  out  2*float_len  twiddle word, registered.
- rd_data_valid  out  1  rd_data is valid.

Behaviour:
- Reset values: state=IDLE, waddr=0, raddr=0, wr_ready=0, wr_drop=0, load_done=0, table_ready=0, rd_data=0, rd_data_valid=0. RAM contents are not cleared.
- FSM states: IDLE, LOAD, READY.
- Transitions:
  - Any state, load_start=1 -> LOAD next cycle; waddr<=0, raddr<=0, table_ready<=0, wr_drop<=0.
  - LOAD, accepted beat with waddr==tf_num-1 -> READY.
  - READY holds until load_start or rst.
- wr_ready = (state==LOAD) && !load_start, combinational. A beat presented in the same cycle as load_start is not accepted.
- Write: when wr_valid && wr_ready, mem[waddr]<=wr_data and waddr<=waddr+1. No back-pressure other than state; one beat per cycle max.
- Completion: on the accepting cycle of the last entry, load_done=1 on the next cycle for exactly 1 cycle, and table_ready=1 from that same cycle.
- wr_valid while state!=LOAD (or while load_start=1): beat dropped, RAM unchanged, wr_drop<=1 (sticky until load_start or rst).
- Read, READY only: rd_en=1 -> rd_data<=mem[raddr] and raddr<=raddr+1 (wraps tf_num-1 -> 0 naturally, tf_addr_len bits).
- rd_data_valid<=rd_en && (state==READY), giving 1-cycle latency.
- rd_en while not READY: raddr holds, rd_data holds its last value, rd_data_valid=0 next cycle.
- Abort mid-load: load_start restarts from entry 0; partial entries are overwritten. Reads are disabled until the new load completes.
- Reload while reading: a rd_en in the same cycle as load_start is still served (state is READY that cycle). From the next cycle reads are refused.
- Reset mid-operation: immediate return to the reset values; a new load is required before reads.
- Same-cycle write and read cannot collide: writes occur only in LOAD and reads only in READY.

Test Plan:
- Reset, then load_start, then 4 back-to-back beats 0x3F800000_00000000, 0x3F3504F3_BF3504F3, 0x00000000_BF800000, 0xBF3504F3_BF3504F3 -> wr_ready=1 for 4 cycles, load_done pulses once 1 cycle after the 4th beat, table_ready=1.
- After the load, rd_en held 6 cycles -> rd_data_valid high cycles 1..6, data sequence entries 0,1,2,3,0,1 (wraparound), one cycle after each rd_en.
- rd_en=1 before any load -> rd_data_valid stays 0, rd_data=0. After loading, the first read returns entry 0, proving raddr held at 0.
- wr_valid=1 in IDLE and in READY with data 0xDEADBEEF_DEADBEEF -> wr_drop=1 and stays 1, and a subsequent read sweep returns the original table unchanged.
- load_start after 2 of 4 beats, then 4 new beats A,B,C,D -> load_done only after D, and reads return A,B,C,D. A beat coincident with load_start is not accepted (wr_ready=0 that cycle).
- Assert rst during LOAD with waddr=2 -> all outputs at reset values in the same cycle (async). Without a subsequent load, rd_en yields no valid.
